// File: rtl/print_arbiter_pkg.sv
// Shared types and default sizing for the print-path arbiter.
package print_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_N       = 3;
  localparam int DEF_TIMEOUT = 65536;
  localparam int DEF_GAP     = 2;

endpackage

// File: rtl/print_arbiter_if.sv
// Requester and printer handshake bundle for print_arbiter.
interface print_arbiter_if import print_arb_pkg::*; #(parameter int N = DEF_N);

  logic [N-1:0]    req_i;
  logic [N-1:0]    type_i;
  logic [32*N-1:0] data_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic [N-1:0]    err_o;
  logic            busy_o;
  logic            req_tx;
  logic            type_tx;
  logic [31:0]     dout_tx;
  logic            ack_tx;

  // Requesters and printer side
  modport master (
    output req_i, type_i, data_i, ack_tx,
    input  gnt_o, done_o, err_o, busy_o, req_tx, type_tx, dout_tx
  );

  // Arbiter side
  modport slave (
    input  req_i, type_i, data_i, ack_tx,
    output gnt_o, done_o, err_o, busy_o, req_tx, type_tx, dout_tx
  );

endinterface

// File: rtl/print_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping mod N.
module rr_picker
  import print_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  int k;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    k      = 0;
    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        idx       = IW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/print_arbiter.sv
// Round-robin owner of the serial print path: grant, hold req_tx until ack or timeout, then gap.
module print_arbiter
  import print_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input logic            clk,
  input logic            rst,
  print_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [N-1:0]    err_q, err_d;
  logic            req_tx_q, req_tx_d;
  logic            type_tx_q, type_tx_d;
  logic [31:0]     dout_tx_q, dout_tx_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [N-1:0]    pick_onehot;
  logic            sel_type;
  logic [31:0]     sel_data;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req    (bus.req_i),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    sel_type = 1'b0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_onehot[k]) begin
        sel_type = bus.type_i[k];
        sel_data = bus.data_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    req_tx_d  = req_tx_q;
    type_tx_d = type_tx_q;
    dout_tx_d = dout_tx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_idx;
          gnt_d     = pick_onehot;
          type_tx_d = sel_type;
          dout_tx_d = sel_data;
          req_tx_d  = 1'b1;
          timer_d   = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        timer_d = timer_q + TW'(1);
        // A late ack on the timeout cycle still counts as success
        if (bus.ack_tx || (timer_q == TW'(TIMEOUT - 1))) begin
          if (bus.ack_tx) done_d = gnt_q;
          else            err_d  = gnt_q;
          req_tx_d = 1'b0;
          gnt_d    = '0;
          ptr_d    = owner_q;
          gap_d    = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IW'(N - 1);
      owner_q   <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      req_tx_q  <= 1'b0;
      type_tx_q <= 1'b0;
      dout_tx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      req_tx_q  <= req_tx_d;
      type_tx_q <= type_tx_d;
      dout_tx_q <= dout_tx_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.req_tx  = req_tx_q;
  assign bus.type_tx = type_tx_q;
  assign bus.dout_tx = dout_tx_q;

endmodule

// File: tb/tb_print_arbiter.sv
// Directed bench for print_arbiter: a default-timeout instance and a TIMEOUT=16 instance.
module tb_print_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  print_arbiter_if #(.N(3)) bus ();
  print_arbiter_if #(.N(3)) bus_to ();

  print_arbiter #(.N(3), .TIMEOUT(65536), .GAP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  print_arbiter #(.N(3), .TIMEOUT(16), .GAP(2)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  always #5 clk = ~clk;

  task automatic wait_rise(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((which == 0) ? bus.req_tx : bus_to.req_tx) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.gnt_o !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b expected 000", bus.gnt_o); end
    n_cmp++; if (bus.done_o !== 3'b000 || bus.err_o !== 3'b000) begin n_bad++; $display("FAIL reset_done_err: got %b/%b expected 000/000", bus.done_o, bus.err_o); end
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.req_tx !== 1'b0) begin n_bad++; $display("FAIL reset_busy_req: got %b/%b expected 0/0", bus.busy_o, bus.req_tx); end
    n_cmp++; if (bus.dout_tx !== 32'h0 || bus.type_tx !== 1'b0) begin n_bad++; $display("FAIL reset_payload: got %h/%b expected 0/0", bus.dout_tx, bus.type_tx); end
    rst = 1'b0;
    bus.type_i = 3'b000;
    bus.data_i[95:64] = 32'h0000_0041;
    bus.req_i = 3'b100;
    @(negedge clk);
    n_cmp++; if (bus.gnt_o !== 3'b100) begin n_bad++; $display("FAIL first_gnt: got %b expected 100", bus.gnt_o); end
    n_cmp++; if (bus.dout_tx[7:0] !== 8'h41 || bus.type_tx !== 1'b0) begin n_bad++; $display("FAIL first_payload: got %h/%b expected 41/0", bus.dout_tx[7:0], bus.type_tx); end
    n_cmp++; if (bus.req_tx !== 1'b1 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL first_req_tx: got %b/%b expected 1/1", bus.req_tx, bus.busy_o); end
    bus.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 3'b100 || bus.req_tx !== 1'b0) begin n_bad++; $display("FAIL first_done: got %b/%b expected 100/0", bus.done_o, bus.req_tx); end
    bus.ack_tx = 1'b0;
    bus.req_i = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_word();
    int  low;
    int  extra_done;
    bit  held;
    bit  ok;
    bus.type_i = 3'b001;
    bus.data_i[31:0] = 32'hDEAD_BEEF;
    bus.req_i = 3'b001;
    @(negedge clk);
    n_cmp++; if (bus.gnt_o !== 3'b001) begin n_bad++; $display("FAIL word_gnt: got %b expected 001", bus.gnt_o); end
    n_cmp++; if (bus.dout_tx !== 32'hDEAD_BEEF || bus.type_tx !== 1'b1) begin n_bad++; $display("FAIL word_payload: got %h/%b expected deadbeef/1", bus.dout_tx, bus.type_tx); end
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_tx !== 1'b1 || bus.done_o !== 3'b000 || bus.gnt_o !== 3'b001) held = 1'b0;
    end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL word_hold: got %b expected 1", held); end
    bus.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 3'b001 || bus.req_tx !== 1'b0 || bus.gnt_o !== 3'b000) begin n_bad++; $display("FAIL word_done: got %b/%b/%b expected 001/0/000", bus.done_o, bus.req_tx, bus.gnt_o); end
    bus.ack_tx = 1'b0;
    // Leaving req_i[0] high makes it a fresh request once IDLE samples it
    low = 1;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done_o !== 3'b000) extra_done++;
      if (bus.req_tx === 1'b1) break;
      low++;
    end
    n_cmp++; if (extra_done !== 0) begin n_bad++; $display("FAIL word_done_pulse: got %0d extra expected 0", extra_done); end
    n_cmp++; if (low !== 3) begin n_bad++; $display("FAIL word_gap: got %0d low cycles expected 3", low); end
    bus.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 3'b001) begin n_bad++; $display("FAIL word_redone: got %b expected 001", bus.done_o); end
    bus.ack_tx = 1'b0;
    bus.req_i = 3'b000;
    repeat (4) @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic test_contention();
    logic [31:0] pay [3];
    logic [2:0]  exp;
    int          w;
    bit          ok;
    pay[0] = 32'h1000_00A0;
    pay[1] = 32'h2000_00B1;
    pay[2] = 32'h3000_00C2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data_i = {pay[2], pay[1], pay[0]};
    bus.type_i = 3'b010;
    bus.req_i  = 3'b111;
    for (int i = 0; i < 6; i++) begin
      w = i % 3;
      exp = 3'b001 << w;
      wait_rise(0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL cont_rise%0d: got %b expected 1", i, ok); end
      n_cmp++; if (bus.gnt_o !== exp) begin n_bad++; $display("FAIL cont_gnt%0d: got %b expected %b", i, bus.gnt_o, exp); end
      n_cmp++; if (bus.dout_tx !== pay[w] || bus.type_tx !== (w == 1)) begin n_bad++; $display("FAIL cont_payload%0d: got %h/%b expected %h/%b", i, bus.dout_tx, bus.type_tx, pay[w], (w == 1)); end
      bus.ack_tx = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.done_o !== exp) begin n_bad++; $display("FAIL cont_done%0d: got %b expected %b", i, bus.done_o, exp); end
      bus.ack_tx = 1'b0;
    end
    bus.req_i = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    bit clean;
    bus_to.data_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    bus_to.type_i = 3'b000;
    bus_to.req_i  = 3'b010;
    @(negedge clk);
    n_cmp++; if (bus_to.gnt_o !== 3'b010) begin n_bad++; $display("FAIL to_gnt: got %b expected 010", bus_to.gnt_o); end
    clean = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (bus_to.req_tx !== 1'b1 || bus_to.err_o !== 3'b000 || bus_to.done_o !== 3'b000) clean = 1'b0;
    end
    n_cmp++; if (clean !== 1'b1) begin n_bad++; $display("FAIL to_early: got %b expected 1", clean); end
    @(negedge clk);
    n_cmp++; if (bus_to.err_o !== 3'b010 || bus_to.done_o !== 3'b000) begin n_bad++; $display("FAIL to_err: got %b/%b expected 010/000", bus_to.err_o, bus_to.done_o); end
    n_cmp++; if (bus_to.req_tx !== 1'b0 || bus_to.gnt_o !== 3'b000) begin n_bad++; $display("FAIL to_release: got %b/%b expected 0/000", bus_to.req_tx, bus_to.gnt_o); end
    bus_to.req_i = 3'b101;
    wait_rise(1, ok);
    n_cmp++; if (ok !== 1'b1 || bus_to.gnt_o !== 3'b100) begin n_bad++; $display("FAIL to_next_gnt: got %b/%b expected 1/100", ok, bus_to.gnt_o); end
    n_cmp++; if (bus_to.dout_tx !== 32'h2222_2222) begin n_bad++; $display("FAIL to_next_payload: got %h expected 22222222", bus_to.dout_tx); end
    repeat (15) @(negedge clk);
    // Ack lands on the same edge as the timeout, then lingers one more cycle
    bus_to.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_to.done_o !== 3'b100 || bus_to.err_o !== 3'b000) begin n_bad++; $display("FAIL to_coincide: got %b/%b expected 100/000", bus_to.done_o, bus_to.err_o); end
    bus_to.req_i = 3'b001;
    @(negedge clk);
    bus_to.ack_tx = 1'b0;
    n_cmp++; if (bus_to.done_o !== 3'b000 || bus_to.err_o !== 3'b000) begin n_bad++; $display("FAIL to_ack2: got %b/%b expected 000/000", bus_to.done_o, bus_to.err_o); end
    wait_rise(1, ok);
    n_cmp++; if (ok !== 1'b1 || bus_to.gnt_o !== 3'b001) begin n_bad++; $display("FAIL to_third_gnt: got %b/%b expected 1/001", ok, bus_to.gnt_o); end
    bus_to.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_to.done_o !== 3'b001) begin n_bad++; $display("FAIL to_third_done: got %b expected 001", bus_to.done_o); end
    bus_to.ack_tx = 1'b0;
    bus_to.req_i  = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit ok;
    bus.req_i = 3'b010;
    wait_rise(0, ok);
    n_cmp++; if (ok !== 1'b1 || bus.gnt_o !== 3'b010) begin n_bad++; $display("FAIL mr_gnt: got %b/%b expected 1/010", ok, bus.gnt_o); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_tx !== 1'b0 || bus.gnt_o !== 3'b000 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL mr_idle: got %b/%b/%b expected 0/000/0", bus.req_tx, bus.gnt_o, bus.busy_o); end
    n_cmp++; if (bus.done_o !== 3'b000 || bus.err_o !== 3'b000) begin n_bad++; $display("FAIL mr_no_report: got %b/%b expected 000/000", bus.done_o, bus.err_o); end
    rst = 1'b0;
    bus.req_i = 3'b111;
    @(negedge clk);
    n_cmp++; if (bus.gnt_o !== 3'b001 || bus.done_o !== 3'b000 || bus.err_o !== 3'b000) begin n_bad++; $display("FAIL mr_ptr: got %b/%b/%b expected 001/000/000", bus.gnt_o, bus.done_o, bus.err_o); end
    bus.ack_tx = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 3'b001) begin n_bad++; $display("FAIL mr_done: got %b expected 001", bus.done_o); end
    bus.ack_tx = 1'b0;
    bus.req_i  = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_i     = '0;
    bus.type_i    = '0;
    bus.data_i    = '0;
    bus.ack_tx    = 1'b0;
    bus_to.req_i  = '0;
    bus_to.type_i = '0;
    bus_to.data_i = '0;
    bus_to.ack_tx = 1'b0;
    test_reset();
    test_single_word();
    test_contention();
    test_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
